// File: rtl/test_if.sv
// test_if: endpoint-side bus of the shared-bus arbiter/router.
//   pndng  : per-endpoint "transmit FIFO non-empty" flags
//   D_pop  : per-endpoint head-of-FIFO data
//   pop    : per-endpoint pop strobe (arbiter -> endpoint)
//   push   : per-endpoint push strobe (arbiter -> endpoint)
//   D_push : per-endpoint receive data (arbiter -> endpoint)
// The master modport is the arbiter; the slave modport is the endpoint side.
interface test_if #(
  parameter int devices = 4,
  parameter int width   = 16
);
  logic [devices-1:0]            pndng;
  logic [devices-1:0][width-1:0] D_pop;
  logic [devices-1:0]            pop;
  logic [devices-1:0]            push;
  logic [devices-1:0][width-1:0] D_push;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push
  );
endinterface

// File: rtl/test.sv
// test: round-robin shared-bus arbiter and packet router.
// One pending endpoint is granted per transaction (IDLE -> SEND -> GAP), its
// head packet is popped, and the packet is pushed to the endpoint named in
// its top 8 bits, or to every other endpoint when that ID is `broadcast`.
// Out-of-range and self-addressed packets are popped and dropped.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : test_if.master (pndng/D_pop in, pop/push/D_push out, all registered)
module test #(
  parameter int         devices   = 4,
  parameter int         width     = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic   clk,
  input  logic   reset,
  test_if.master bus
);
  localparam int IDW = $clog2(devices);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e                        state_q, state_d;
  logic [IDW-1:0]                last_q, last_d;
  logic [IDW-1:0]                src_q, src_d;
  logic [width-1:0]              pkt_q, pkt_d;
  logic [devices-1:0]            pop_q, pop_d;
  logic [devices-1:0]            push_q, push_d;
  logic [devices-1:0][width-1:0] dpush_q, dpush_d;

  logic [IDW-1:0]     win;
  logic               win_vld;
  logic [devices-1:0] win_onehot;
  logic [devices-1:0] dst_mask;
  logic [7:0]         dst_id;

  assign bus.pop    = pop_q;
  assign bus.push   = push_q;
  assign bus.D_push = dpush_q;

  // Round-robin search: first pending endpoint starting just after the
  // previous winner, wrapping around.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= devices; k++) begin
      int idx;
      idx = (int'(last_q) + k) % devices;
      if (!win_vld && bus.pndng[IDW'(idx)]) begin
        win     = IDW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < devices; i++) begin
      if (win == IDW'(i)) win_onehot[i] = 1'b1;
    end
  end

  // Destination decode from the latched packet header.
  assign dst_id = pkt_q[width-1 -: 8];

  always_comb begin
    dst_mask = '0;
    for (int i = 0; i < devices; i++) begin
      if (dst_id == broadcast) begin
        dst_mask[i] = (src_q != IDW'(i));
      end else if (int'(dst_id) == i && int'(dst_id) != int'(src_q)) begin
        dst_mask[i] = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    pkt_d   = pkt_q;
    pop_d   = '0;
    push_d  = '0;
    dpush_d = dpush_q;  // D_push holds between transactions

    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          pkt_d   = bus.D_pop[win];
          src_d   = win;
          last_d  = win;
          pop_d   = win_onehot;
          state_d = SEND;
        end
      end
      SEND: begin
        push_d  = dst_mask;
        dpush_d = {devices{pkt_q}};
        state_d = GAP;
      end
      GAP: begin
        // Lets endpoint FIFOs refresh pndng after the pop before resampling.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDW'(devices - 1);
      src_q   <= '0;
      pkt_q   <= '0;
      pop_q   <= '0;
      push_q  <= '0;
      // NOTE: the D_push data array is reset because it is a visible output
      // with a defined reset value, not merely an internal storage buffer.
      dpush_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      pkt_q   <= pkt_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      dpush_q <= dpush_d;
    end
  end
endmodule

// File: tb/tb_test.sv
// tb_test: directed bench for the round-robin arbiter/router with endpoint
// transmit-FIFO models and a scoreboard of expected pops and pushes.
module tb_test;
  typedef struct packed {
    logic [3:0]  mask;
    logic [15:0] data;
  } push_t;

  logic clk = 1'b0;
  logic reset;

  test_if #(.devices(4), .width(16)) bus ();

  test #(.devices(4), .width(16), .broadcast(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [15:0] txq [4][$];
  int          exp_pop[$];
  push_t       exp_push[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_pop_cyc = -1;
  bit chk_spacing = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.pndng[i] = (txq[i].size() != 0);
      bus.D_pop[i] = (txq[i].size() != 0) ? txq[i][0] : 16'h0000;
    end
  endtask

  function automatic bit busy();
    bit b;
    b = (exp_pop.size() != 0) || (exp_push.size() != 0);
    for (int i = 0; i < 4; i++) if (txq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic monitor();
    if (bus.pop !== 4'b0000) begin
      check("pop_onehot", 64'($onehot(bus.pop)), 64'(1));
      if (exp_pop.size() == 0) begin
        check("pop_unexpected", 64'(bus.pop), 64'(0));
      end else begin
        int e;
        e = exp_pop.pop_front();
        check("pop_idx", 64'(bus.pop), 64'(1) << e);
        if (chk_spacing && last_pop_cyc >= 0)
          check("pop_spacing", 64'(cyc - last_pop_cyc), 64'(3));
        last_pop_cyc = cyc;
      end
    end
    if (bus.push !== 4'b0000) begin
      check("pop_push_excl", 64'(bus.pop & bus.push), 64'(0));
      if (exp_push.size() == 0) begin
        check("push_unexpected", 64'(bus.push), 64'(0));
      end else begin
        push_t p;
        p = exp_push.pop_front();
        check("push_mask", 64'(bus.push), 64'(p.mask));
        for (int i = 0; i < 4; i++)
          if (p.mask[i]) check("push_data", 64'(bus.D_push[i]), 64'(p.data));
      end
    end
  endtask

  // One clock: endpoints pop on the edge that ends their pop strobe,
  // then inputs are refreshed and outputs checked 1 time unit later.
  task automatic tick();
    logic [3:0] pp;
    pp = bus.pop;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 4; i++)
      if (pp[i] && txq[i].size() != 0) void'(txq[i].pop_front());
    #1;
    drive_inputs();
    monitor();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(busy()), 64'(0));
    if (busy()) begin
      for (int i = 0; i < 4; i++) txq[i].delete();
      exp_pop.delete();
      exp_push.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    drive_inputs();
    repeat (2) tick();
    reset = 1'b0;

    // Reset state and a long idle stretch.
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_pop", 64'(bus.pop), 64'(0));
      check("idle_push", 64'(bus.push), 64'(0));
      check("idle_dpush", 64'(bus.D_push), 64'(0));
    end

    // Unicast from endpoint 1 to endpoint 2, with exact latency.
    txq[1].push_back(16'h02AB);
    exp_pop.push_back(1);
    exp_push.push_back('{mask: 4'b0100, data: 16'h02AB});
    drive_inputs();
    tick();
    check("uni_pop", 64'(bus.pop), 64'(4'b0010));
    tick();
    check("uni_push", 64'(bus.push), 64'(4'b0100));
    check("uni_data", 64'(bus.D_push[2]), 64'(16'h02AB));
    tick();
    check("uni_push_off", 64'(bus.push), 64'(0));
    check("uni_hold", 64'(bus.D_push[2]), 64'(16'h02AB));
    wait_done(20);

    // Broadcast from endpoint 3.
    txq[3].push_back(16'hFF5A);
    exp_pop.push_back(3);
    exp_push.push_back('{mask: 4'b0111, data: 16'hFF5A});
    drive_inputs();
    wait_done(20);

    // All endpoints continuously pending: strict rotation at 3-cycle spacing.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        logic [15:0] w;
        logic [3:0]  m;
        w = {8'((i + 1) % 4), 8'(8'h10 * i + r)};
        m = 4'(1 << ((i + 1) % 4));
        txq[i].push_back(w);
        exp_pop.push_back(i);
        exp_push.push_back('{mask: m, data: w});
      end
    end
    last_pop_cyc = -1;
    chk_spacing = 1'b1;
    drive_inputs();
    wait_done(60);
    chk_spacing = 1'b0;

    // Out-of-range and self-addressed packets: popped, never pushed.
    txq[0].push_back(16'h0711);
    txq[0].push_back(16'h0022);
    exp_pop.push_back(0);
    exp_pop.push_back(0);
    drive_inputs();
    wait_done(20);

    // Reset during SEND: popped packet is lost, priority restarts at 0.
    txq[0].push_back(16'h0133);
    exp_pop.push_back(0);
    drive_inputs();
    tick();
    check("rst_pre_pop", 64'(bus.pop), 64'(4'b0001));
    reset = 1'b1;
    tick();
    check("rst_push", 64'(bus.push), 64'(0));
    check("rst_pop", 64'(bus.pop), 64'(0));
    check("rst_dpush", 64'(bus.D_push), 64'(0));
    reset = 1'b0;
    txq[0].push_back(16'h0144);
    txq[1].push_back(16'h0211);
    exp_pop.push_back(0);
    exp_pop.push_back(1);
    exp_push.push_back('{mask: 4'b0010, data: 16'h0144});
    exp_push.push_back('{mask: 4'b0100, data: 16'h0211});
    drive_inputs();
    wait_done(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/test.md
# test

Shared-bus arbiter and router connecting `devices` FIFO-interfaced endpoints of `width`-bit packets. Each endpoint exposes the head of its transmit FIFO. The block grants one pending endpoint at a time in round-robin order, pops its packet, and pushes it to the addressed endpoint's receive FIFO, or to all other endpoints on broadcast. It is the device under test of the bus verification environment, with one agent/driver pair per endpoint.

## Interface
- `devices`, 4 — number of endpoints (2..16).
- `width`, 16 — packet width in bits (≥ 9).
- `broadcast`, 8'hFF — destination ID meaning "all endpoints except the source".
- `clk`  in  1  — single clock; all logic is on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `pndng`  in  [devices]  — bit i high: endpoint i's transmit FIFO is non-empty.
- `D_pop`  in  [devices][width]  — head-of-FIFO data of endpoint i; valid while `pndng[i]` is high.
- `pop`  out  [devices]  — one-cycle strobe; endpoint i removes its head entry.
- `push`  out  [devices]  — one-cycle strobe; endpoint i writes `D_push[i]` into its receive FIFO.
- `D_push`  out  [devices][width]  — data to endpoint i.

## Operation
- Packet format: bits [width-1:width-8] = destination ID; bits [width-9:0] = payload. The whole word, header included, is forwarded unchanged.
- The FSM has three states: IDLE, SEND, GAP.
- **IDLE**:
  - If `pndng` is zero, stay in IDLE.
  - Otherwise select winner w as the first set bit of `pndng`, searching cyclically from `last+1`.
  - Latch `buf <= D_pop[w]`, `src <= w`, `last <= w`; drive `pop <= onehot(w)`; go to SEND.
- **SEND**:
  - `pop <= 0`.
  - Compute destination mask from `buf`'s ID:
    - ID == broadcast: all endpoints except `src`.
    - ID < devices and ID != src: onehot(ID).
    - Otherwise (out of range, or self-addressed): empty mask. The packet is dropped; its pop has already occurred.
  - `push <= mask`; every `D_push[i] <= buf`; go to GAP.
- **GAP**: `push <= 0`; go to IDLE. This cycle gives endpoint FIFOs time to update `pndng` after the pop.
- Round robin: every endpoint with `pndng` held high is served within `devices` transactions. No endpoint is starved.
- `D_push` holds its last value between transactions. Receivers sample it only on `push`.

## Timing
- All outputs are registered.
- Reset values: `pop` = 0, `push` = 0, all `D_push` = 0, state = IDLE, `last` = devices-1 (so endpoint 0 has first priority).
- Transaction timeline:
  - Edge E: IDLE samples `pndng`.
  - Cycle after E: `pop[w]` high for exactly one cycle.
  - Cycle after that: `push` mask high for exactly one cycle, with `D_push` valid.
- Latency: `pndng` sampled → push asserted = 2 cycles.
- Throughput: one packet per 3 cycles.
- At most one `pop` bit is ever high. `pop` and `push` are never high in the same cycle.
- `pndng` changes during SEND/GAP are ignored. They are re-evaluated only in IDLE.
- Reset asserted in any state: the next edge forces reset values. A packet that was already popped but not yet pushed is lost.
- `pndng` deasserting in the same edge as selection has no effect; the winner is still popped.

## Test plan
- Reset, `pndng` = 0 for 20 cycles → `pop` = 0, `push` = 0, `D_push` = 0 throughout.
- Endpoint 1 pending with 16'h02AB → `pop` = 4'b0010 one cycle after sampling; next cycle `push` = 4'b0100 and `D_push[2]` = 16'h02AB.
- Endpoint 3 pending with 16'hFF5A → `pop[3]` pulse, then `push` = 4'b0111 with 16'hFF5A on `D_push[0..2]`.
- All four endpoints continuously pending with valid unicasts → pops occur in order 0,1,2,3,0 at 3-cycle spacing.
- Endpoint 0 sends 16'h0711 (out-of-range ID) and 16'h0022 (self-addressed) → each is popped, and `push` stays 0 for both.
- Assert `reset` during the SEND cycle → next cycle `push` = 0, `pop` = 0; the next grant goes to endpoint 0 first.
